// File: rtl/demux2_buf_pkg.sv
// Shared definitions for the two-channel selector/distributor pair.
// The select rule lives here so both blocks steer bytes identically.
package demux2_buf_pkg;

   localparam int   DEF_DW = 8;
   localparam logic CH0    = 1'b0;
   localparam logic CH1    = 1'b1;

   // Channel 0 only for flags (1,0); every other flag pair maps to channel 1.
   function automatic logic sel_ch(input logic ch0_dmx, input logic ch1_dmx);
      logic ch_s;
      if (ch0_dmx && !ch1_dmx) begin
         ch_s = CH0;
      end else begin
         ch_s = CH1;
      end
      return ch_s;
   endfunction

endpackage

// File: rtl/demux2_buf_if.sv
// Bundle of the source stream, the two consumer streams and the status counters.
interface demux2_buf_if
   import demux2_buf_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int DEPTH = 2,
   parameter int CW    = 8
);
   localparam int NW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          ch0_dmx;
   logic          ch1_dmx;
   logic          out0_valid;
   logic          out0_ready;
   logic [DW-1:0] out0_data;
   logic          out1_valid;
   logic          out1_ready;
   logic [DW-1:0] out1_data;
   logic [NW-1:0] count0;
   logic [NW-1:0] count1;
   logic [CW-1:0] bytes0;
   logic [CW-1:0] bytes1;

   modport master (
      output in_valid, in_data, ch0_dmx, ch1_dmx, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
      input  count0, count1, bytes0, bytes1
   );

   modport slave (
      input  in_valid, in_data, ch0_dmx, ch1_dmx, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out1_valid, out1_data,
      output count0, count1, bytes0, bytes1
   );

endinterface

// File: rtl/demux2_buf_fifo_ch.sv
// First-word-fall-through FIFO for one output channel.
// Full/empty come from the occupancy count; storage itself is never reset.
module demux2_buf_fifo_ch #(
   parameter int DW    = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]    CNT_ZERO = (AW + 1)'(0);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == CNT_ZERO);
   assign count     = count_r;
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   // Storage write port.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= CNT_ZERO;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Head entry is shown only while occupied so stale storage never leaks out.
   always_comb begin
      rdata = {DW{1'b0}};
      if (!empty) begin
         rdata = mem_r[rd_ptr_r];
      end else begin
         rdata = {DW{1'b0}};
      end
   end

endmodule

// File: rtl/demux2_buf.sv
// Two-channel byte distributor: steers each accepted byte by the shared select
// rule into one of two independently drained FWFT FIFOs.
module demux2_buf
   import demux2_buf_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int DEPTH = 2,
   parameter int CW    = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   demux2_buf_if.slave bus
);
   localparam int            NW        = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] BYTES_ONE = CW'(1);

   logic          sel_s;
   logic          ready_s;
   logic          push0_s;
   logic          push1_s;
   logic          full0_s;
   logic          full1_s;
   logic          empty0_s;
   logic          empty1_s;
   logic [DW-1:0] rdata0_s;
   logic [DW-1:0] rdata1_s;
   logic [NW-1:0] count0_s;
   logic [NW-1:0] count1_s;
   logic [CW-1:0] bytes0_r;
   logic [CW-1:0] bytes1_r;

   // Readiness follows only the selected channel's fullness, never in_valid.
   always_comb begin
      sel_s = sel_ch(bus.ch0_dmx, bus.ch1_dmx);
      if (sel_s == CH0) begin
         ready_s = !full0_s;
      end else begin
         ready_s = !full1_s;
      end
      push0_s = bus.in_valid && ready_s && (sel_s == CH0);
      push1_s = bus.in_valid && ready_s && (sel_s == CH1);
   end

   demux2_buf_fifo_ch #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push0_s),
      .pop     (bus.out0_ready),
      .wdata   (bus.in_data),
      .rdata   (rdata0_s),
      .full    (full0_s),
      .empty   (empty0_s),
      .count   (count0_s)
   );

   demux2_buf_fifo_ch #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push1_s),
      .pop     (bus.out1_ready),
      .wdata   (bus.in_data),
      .rdata   (rdata1_s),
      .full    (full1_s),
      .empty   (empty1_s),
      .count   (count1_s)
   );

   // Accepted-byte counters, wrapping silently.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bytes0_r <= {CW{1'b0}};
         bytes1_r <= {CW{1'b0}};
      end else begin
         if (push0_s) begin
            bytes0_r <= bytes0_r + BYTES_ONE;
         end
         if (push1_s) begin
            bytes1_r <= bytes1_r + BYTES_ONE;
         end
      end
   end

   assign bus.in_ready   = ready_s;
   assign bus.out0_valid = !empty0_s;
   assign bus.out0_data  = rdata0_s;
   assign bus.out1_valid = !empty1_s;
   assign bus.out1_data  = rdata1_s;
   assign bus.count0     = count0_s;
   assign bus.count1     = count1_s;
   assign bus.bytes0     = bytes0_r;
   assign bus.bytes1     = bytes1_r;

endmodule

// File: tb/tb_demux2_buf.sv
// Bench for demux2_buf: directed scenarios plus random traffic, each cycle
// compared against a queue-based model of the two channels.
module tb_demux2_buf;
   localparam int DW    = 8;
   localparam int DEPTH = 2;
   localparam int CW    = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   demux2_buf_if #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) bus ();

   demux2_buf #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int max1     = 0;
   int b0       = 0;
   int b1       = 0;
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One clock: drive, compare every output with the model, clock, update model.
   task automatic step(input logic v, input logic f0, input logic f1,
                       input logic [7:0] d, input logic r0, input logic r1);
      bit to1;
      bit rdy;
      bit pop0;
      bit pop1;
      bus.in_valid   = v;
      bus.ch0_dmx    = f0;
      bus.ch1_dmx    = f1;
      bus.in_data    = d;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
      #1;
      to1  = !(f0 && !f1);
      rdy  = to1 ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      pop0 = r0 && (q0.size() > 0);
      pop1 = r1 && (q1.size() > 0);
      check("in_ready",   bus.in_ready,   32'(rdy));
      check("out0_valid", bus.out0_valid, 32'(q0.size() > 0));
      check("out0_data",  bus.out0_data,  (q0.size() > 0) ? 32'(q0[0]) : 32'd0);
      check("out1_valid", bus.out1_valid, 32'(q1.size() > 0));
      check("out1_data",  bus.out1_data,  (q1.size() > 0) ? 32'(q1[0]) : 32'd0);
      check("count0",     bus.count0,     32'(q0.size()));
      check("count1",     bus.count1,     32'(q1.size()));
      check("bytes0",     bus.bytes0,     32'(b0));
      check("bytes1",     bus.bytes1,     32'(b1));
      @(posedge clk);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (v && rdy) begin
         if (to1) begin
            q1.push_back(d);
            b1 = (b1 + 1) % 256;
         end else begin
            q0.push_back(d);
            b0 = (b0 + 1) % 256;
         end
      end
      if (q1.size() > max1) max1 = q1.size();
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_out0_valid", bus.out0_valid, 32'd0);
      check("rst_out1_valid", bus.out1_valid, 32'd0);
      check("rst_out0_data",  bus.out0_data,  32'd0);
      check("rst_out1_data",  bus.out1_data,  32'd0);
      check("rst_count0",     bus.count0,     32'd0);
      check("rst_count1",     bus.count1,     32'd0);
      check("rst_bytes0",     bus.bytes0,     32'd0);
      check("rst_bytes1",     bus.bytes1,     32'd0);
      q0.delete();
      q1.delete();
      b0 = 0;
      b1 = 0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = 8'h00;
      bus.ch0_dmx    = 1'b0;
      bus.ch1_dmx    = 1'b0;
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Routing truth table with both consumers always ready.
      step(1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("route_bytes0", bus.bytes0, 32'd1);
      check("route_bytes1", bus.bytes1, 32'd3);

      // Fill channel 0, then show channel 1 still accepts.
      step(1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
      check("full_count0", bus.count0, 32'd2);
      step(1'b1, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'hB1, 1'b0, 1'b0);
      check("indep_out1_data", bus.out1_data, 32'hB1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      // Push and pop channel 1 in the same cycle.
      step(1'b1, 1'b0, 1'b0, 8'hC5, 1'b0, 1'b1);
      check("pushpop_count1", bus.count1, 32'd1);
      check("pushpop_head",   bus.out1_data, 32'hC5);

      // Full channel 0 refuses even while being drained.
      step(1'b1, 1'b1, 1'b0, 8'hD1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'hD2, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'hD3, 1'b1, 1'b0);
      check("fullpop_count0", bus.count0, 32'd1);

      // Reset mid-stream with both channels holding data.
      step(1'b1, 1'b0, 1'b0, 8'hE1, 1'b0, 1'b0);
      do_reset();
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // 256 pushes to channel 1 wrap its byte counter.
      max1 = 0;
      for (int i = 0; i < 255; i++) begin
         step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0, 1'b1);
      end
      check("wrap_bytes1_255", bus.bytes1, 32'd255);
      step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
      check("wrap_bytes1_0", bus.bytes1, 32'd0);
      check("wrap_max_count1", 32'(max1 <= 1), 32'd1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
              8'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
